// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants: datapath widths, ALU op codes, operand selects.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_SEL_W  = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_AND    = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_OR     = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD    = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR    = 4'b0011;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL    = 4'b0100;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL    = 4'b0101;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB    = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA    = 4'b0111;
  localparam logic [ALU_SEL_W-1:0] ALU_PASS_B = 4'b1010;

  localparam logic A_SEL_REG = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_REG = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage signal bundle; master drives ID/bypass side, slave is the stage.
interface id_ex_stage_if #(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int ALU_SEL_W  = cpu_pkg::ALU_SEL_W
);

  logic                  ID_VALID;
  logic [XLEN-1:0]       ID_PC;
  logic [XLEN-1:0]       ID_RS1_DATA;
  logic [XLEN-1:0]       ID_RS2_DATA;
  logic [XLEN-1:0]       ID_IMM;
  logic [REG_ADDR_W-1:0] ID_RS1;
  logic [REG_ADDR_W-1:0] ID_RS2;
  logic [REG_ADDR_W-1:0] ID_RD;
  logic [ALU_SEL_W-1:0]  ID_ALU_SELECT;
  logic                  ID_A_SEL;
  logic                  ID_B_SEL;
  logic                  ID_REG_WRITE;
  logic                  ID_MEM_READ;
  logic                  ID_MEM_WRITE;
  logic                  EXT_STALL;
  logic                  FLUSH;
  logic [REG_ADDR_W-1:0] EXMEM_RD;
  logic                  EXMEM_REG_WRITE;
  logic [XLEN-1:0]       EXMEM_RESULT;
  logic [REG_ADDR_W-1:0] MEMWB_RD;
  logic                  MEMWB_REG_WRITE;
  logic [XLEN-1:0]       MEMWB_RESULT;
  logic [XLEN-1:0]       ALU_DATA1;
  logic [XLEN-1:0]       ALU_DATA2;
  logic [ALU_SEL_W-1:0]  ALU_SELECT;
  logic [XLEN-1:0]       EX_STORE_DATA;
  logic                  EX_VALID;
  logic                  EX_REG_WRITE;
  logic                  EX_MEM_READ;
  logic                  EX_MEM_WRITE;
  logic [REG_ADDR_W-1:0] EX_RD;
  logic [XLEN-1:0]       EX_PC;
  logic                  LOAD_USE_STALL;

  modport master (
    output ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM, ID_RS1, ID_RS2, ID_RD,
           ID_ALU_SELECT, ID_A_SEL, ID_B_SEL, ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE,
           EXT_STALL, FLUSH, EXMEM_RD, EXMEM_REG_WRITE, EXMEM_RESULT,
           MEMWB_RD, MEMWB_REG_WRITE, MEMWB_RESULT,
    input  ALU_DATA1, ALU_DATA2, ALU_SELECT, EX_STORE_DATA, EX_VALID, EX_REG_WRITE,
           EX_MEM_READ, EX_MEM_WRITE, EX_RD, EX_PC, LOAD_USE_STALL
  );

  modport slave (
    input  ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM, ID_RS1, ID_RS2, ID_RD,
           ID_ALU_SELECT, ID_A_SEL, ID_B_SEL, ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE,
           EXT_STALL, FLUSH, EXMEM_RD, EXMEM_REG_WRITE, EXMEM_RESULT,
           MEMWB_RD, MEMWB_REG_WRITE, MEMWB_RESULT,
    output ALU_DATA1, ALU_DATA2, ALU_SELECT, EX_STORE_DATA, EX_VALID, EX_REG_WRITE,
           EX_MEM_READ, EX_MEM_WRITE, EX_RD, EX_PC, LOAD_USE_STALL
  );

endinterface

// File: rtl/id_ex_stage_forward_mux.sv
// rtl/id_ex_stage_forward_mux.sv - operand bypass select for one source register.
module forward_mux
  import cpu_pkg::*;
#(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src_idx,
  input  logic [XLEN-1:0]       reg_data,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_we,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_we,
  input  logic [XLEN-1:0]       memwb_result,
  output logic [XLEN-1:0]       fwd_data
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_we && (exmem_rd != '0) && (exmem_rd == src_idx);
  assign memwb_hit = memwb_we && (memwb_rd != '0) && (memwb_rd == src_idx);

  // The younger EX/MEM result shadows MEM/WB when both target the same register.
  always_comb begin
    fwd_data = reg_data;
    if (exmem_hit) begin
      fwd_data = exmem_result;
    end else if (memwb_hit) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, stall/flush and operand select.
// Operand bypassing from EX/MEM and MEM/WB is built only when ID_EX_FORWARD_EN is defined.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int ALU_SEL_W  = cpu_pkg::ALU_SEL_W
) (
  input logic         CLK,
  input logic         RESET,
  id_ex_stage_if.slave io
);

  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [ALU_SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic                  a_sel_q, a_sel_d;
  logic                  b_sel_q, b_sel_d;
  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;

  logic                  load_use;
  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;

  // rs2 is compared even for immediate-form ops: cheaper than decoding B_SEL here.
  assign load_use = !io.FLUSH && valid_q && mem_read_q && (rd_q != '0) && io.ID_VALID &&
                    ((rd_q == io.ID_RS1) || (rd_q == io.ID_RS2));

  always_comb begin
    pc_d        = pc_q;
    imm_d       = imm_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_sel_d   = alu_sel_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (io.FLUSH || (!io.EXT_STALL && load_use)) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!io.EXT_STALL) begin
      pc_d        = io.ID_PC;
      imm_d       = io.ID_IMM;
      rs1_data_d  = io.ID_RS1_DATA;
      rs2_data_d  = io.ID_RS2_DATA;
      rs1_d       = io.ID_RS1;
      rs2_d       = io.ID_RS2;
      rd_d        = io.ID_RD;
      alu_sel_d   = io.ID_ALU_SELECT;
      a_sel_d     = io.ID_A_SEL;
      b_sel_d     = io.ID_B_SEL;
      valid_d     = io.ID_VALID;
      reg_write_d = io.ID_REG_WRITE & io.ID_VALID;
      mem_read_d  = io.ID_MEM_READ & io.ID_VALID;
      mem_write_d = io.ID_MEM_WRITE & io.ID_VALID;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_sel_q   <= '0;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_sel_q   <= alu_sel_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  forward_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .src_idx      (rs1_q),
    .reg_data     (rs1_data_q),
    .exmem_rd     (io.EXMEM_RD),
    .exmem_we     (io.EXMEM_REG_WRITE),
    .exmem_result (io.EXMEM_RESULT),
    .memwb_rd     (io.MEMWB_RD),
    .memwb_we     (io.MEMWB_REG_WRITE),
    .memwb_result (io.MEMWB_RESULT),
    .fwd_data     (fwd_rs1)
  );

  forward_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .src_idx      (rs2_q),
    .reg_data     (rs2_data_q),
    .exmem_rd     (io.EXMEM_RD),
    .exmem_we     (io.EXMEM_REG_WRITE),
    .exmem_result (io.EXMEM_RESULT),
    .memwb_rd     (io.MEMWB_RD),
    .memwb_we     (io.MEMWB_REG_WRITE),
    .memwb_result (io.MEMWB_RESULT),
    .fwd_data     (fwd_rs2)
  );
`else
  logic unused_bypass;

  assign unused_bypass = ^{io.EXMEM_RD, io.EXMEM_REG_WRITE, io.EXMEM_RESULT,
                           io.MEMWB_RD, io.MEMWB_REG_WRITE, io.MEMWB_RESULT};
  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;
`endif

  assign io.ALU_DATA1      = (a_sel_q == A_SEL_PC)  ? pc_q  : fwd_rs1;
  assign io.ALU_DATA2      = (b_sel_q == B_SEL_IMM) ? imm_q : fwd_rs2;
  assign io.EX_STORE_DATA  = fwd_rs2;
  assign io.ALU_SELECT     = alu_sel_q;
  assign io.EX_VALID       = valid_q;
  assign io.EX_REG_WRITE   = reg_write_q;
  assign io.EX_MEM_READ    = mem_read_q;
  assign io.EX_MEM_WRITE   = mem_write_q;
  assign io.EX_RD          = rd_q;
  assign io.EX_PC          = pc_q;
  assign io.LOAD_USE_STALL = load_use;

endmodule
